imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Writer side of the instruction memory: accepts a byte stream (e.g. from a UART receiver), packs bytes little-endian into 32-bit words and drives a synchronous word-write port into instruction memory.
- Sits between the host byte link and the instruction memory.
- Holds the CPU in reset (cpu_hold) until a complete, checksum-verified image has been written.
- Image format: one header byte N (word count), then 4*N payload bytes, then one XOR checksum byte.

Parameters:
- DEPTH, 64, number of instruction words in the memory; the maximum legal N.
- ADDR_W, 6, word-address width; must equal clog2(DEPTH). This matches the memory's pc[7:2] word indexing.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  incoming byte.
- byte_ready  out  1  loader can accept a byte; a transfer occurs on any edge where byte_valid && byte_ready.
- wr_en  out  1  one-cycle instruction-memory write strobe.
- wr_addr  out  ADDR_W  word index being written.
- wr_data  out  32  word being written.
- cpu_hold  out  1  keeps the CPU in reset while high.
- done  out  1  image loaded and verified.
- error  out  1  image rejected (bad header or bad checksum).

Behaviour:
- Reset values (asynchronous, on rst=1):
  - state=S_HDR, byte_ready=1, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0.
  - Internal word counter, byte-lane counter (2 bits), partial word and running checksum all cleared to 0.
- States: S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR.
- byte_ready is 1 in S_HDR, S_DATA and S_CSUM; it is 0 in S_DONE and S_ERR. No bytes are accepted in the terminal states.
- S_HDR, on transfer:
  - Latch N = byte_data; set checksum = byte_data.
  - N > DEPTH -> S_ERR.
  - N == 0 -> S_CSUM.
  - Otherwise -> S_DATA.
- S_DATA, on transfer:
  - Place the byte in lane [8*lane +: 8] of the partial word; checksum ^= byte_data; lane increments and wraps 3 -> 0.
  - When the lane-3 byte is accepted, the full word is registered: on the next cycle wr_en=1 for exactly one cycle, with wr_addr = current word index and wr_data = assembled word.
  - The word index then increments.
  - After word N-1 completes -> S_CSUM.
  - Write latency: 1 cycle after the edge that accepts the 4th byte.
  - Back-to-back bytes are accepted at full rate, with no stall during a write.
- S_CSUM, on transfer:
  - byte_data == checksum -> S_DONE: done=1, cpu_hold=0 from the next cycle.
  - Otherwise -> S_ERR: error=1, cpu_hold stays 1.
  - The final data word's wr_en may coincide with the checksum-accept cycle; both must take effect.
- S_DONE and S_ERR are terminal; only rst leaves them.
- Gaps: byte_valid low holds all state; there is no timeout.
- Reset mid-operation:
  - The partial word is discarded and no write is issued.
  - Words already written remain in memory; the loader does not clear memory.
- wr_addr never exceeds DEPTH-1; the header check guarantees this.
- done and error are never both 1.

Decomposition:
- Shared package imem_loader_pkg holds:
  - the state enum (S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR);
  - IMEM_DEPTH = 64;
  - IMEM_ADDR_W = 6.
- Sub-module imem_word_assembler contains the lane counter, the partial-word register and the registered wr_en/wr_data pulse generator. The top FSM owns the header, checksum, word counter and status outputs.

Test Plan:
- Two-word load. Bytes 02, 93 00 50 00, 13 01 A0 00, 73 with valid held high.
  - Required: write addr0=0x00500093, then write addr1=0x00A00113, each 1 cycle after its 4th byte.
  - Required: done=1 and cpu_hold=0 after byte 0x73; byte_ready=0 thereafter.
- Same stream with checksum byte 0x74.
  - Required: both writes occur; error=1, done=0, cpu_hold=1, byte_ready=0.
- Header 0x41 (65 > DEPTH).
  - Required: S_ERR next cycle, error=1, zero wr_en pulses, later bytes ignored.
- Header 0x00 followed by checksum 0x00.
  - Required: done=1, cpu_hold=0, zero writes.
- The two-word stream with byte_valid toggled 1/0 pseudo-randomly.
  - Required: identical write sequence and final status as the first scenario.
- Header 02 then bytes 93 00, then rst pulsed asynchronously mid-cycle.
  - Required: no wr_en pulse; all outputs return to their reset values immediately.
  - Required: a following full two-word stream loads correctly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader_pkg
//  Purpose  : Shared types and constants for the instruction-memory program
//             loader: loader state encoding and memory geometry.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

    // Instruction memory geometry; the address width matches pc[7:2] indexing.
    localparam int IMEM_DEPTH  = 64;
    localparam int IMEM_ADDR_W = 6;

    // Loader sequencing: header byte, payload, checksum, then terminal states.
    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } loader_state_t;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : imem_word_assembler
//  Purpose  : Packs accepted payload bytes little-endian into 32-bit words and
//             emits a registered one-cycle write strobe per completed word.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             lane_en           - a payload byte is accepted this cycle
//             byte_data [7:0]   - the payload byte
//             word_addr         - word index the current word belongs to
//             word_done         - lane-3 byte accepted this cycle (comb)
//             wr_en             - one-cycle memory write strobe (registered)
//             wr_addr, wr_data  - registered write address / data
//  Revision : 1.0  initial release
// ============================================================================
module imem_word_assembler
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lane_en,
    input  logic [7:0]        byte_data,
    input  logic [ADDR_W-1:0] word_addr,
    output logic              word_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data
);

    logic [1:0]  r_lane;
    logic [31:0] r_partial;
    logic [31:0] w_word;
    logic        r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0] r_wr_data;

    // The incoming byte merged into the partial word. On the lane-3 byte this
    // is the complete word, which is registered straight into the write port
    // so back-to-back bytes never stall behind a write.
    always_comb begin
        w_word = r_partial;
        w_word[8*r_lane +: 8] = byte_data;
    end

    assign word_done = lane_en && (r_lane == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane    <= 2'd0;
            r_partial <= 32'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 32'd0;
        end else begin
            r_wr_en <= word_done;
            if (lane_en) begin
                r_lane    <= r_lane + 2'd1;
                r_partial <= w_word;
            end
            if (word_done) begin
                r_wr_addr <= word_addr;
                r_wr_data <= w_word;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule : imem_word_assembler
`default_nettype wire

// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_program_loader
//  Purpose  : Receives an image (N, 4*N payload bytes, XOR checksum) over a
//             valid/ready byte link, writes it into instruction memory and
//             holds the CPU in reset until the image is verified.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             byte_valid/ready  - byte link handshake
//             byte_data [7:0]   - incoming byte
//             wr_en/addr/data   - instruction-memory word-write port
//             cpu_hold          - CPU reset hold, released on success
//             done / error      - image verified / image rejected
//  Revision : 1.0  initial release
// ============================================================================
module imem_program_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [8:0] C_DEPTH = 9'(DEPTH);

    loader_state_t     r_state;
    loader_state_t     w_state_next;
    logic [7:0]        r_csum;
    logic [ADDR_W-1:0] r_word_idx;
    logic [ADDR_W-1:0] r_last_idx;
    logic              w_xfer;
    logic              w_lane_en;
    logic              w_word_done;
    logic              w_hdr_bad;

    assign byte_ready = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_xfer     = byte_valid && byte_ready;
    assign w_lane_en  = w_xfer && (r_state == S_DATA);
    assign w_hdr_bad  = ({1'b0, byte_data} > C_DEPTH);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_HDR: begin
                if (w_xfer) begin
                    if (w_hdr_bad) begin
                        w_state_next = S_ERR;
                    end else if (byte_data == 8'd0) begin
                        w_state_next = S_CSUM;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_word_done && (r_word_idx == r_last_idx)) begin
                    w_state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_xfer) begin
                    w_state_next = (byte_data == r_csum) ? S_DONE : S_ERR;
                end
            end
            default: w_state_next = r_state;
        endcase
    end

    // ----------------------------------------------- header / checksum / index
    // N itself is not kept; only the index of the last word is needed, which
    // is N-1 and therefore always fits the word-address width for N <= DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum     <= 8'd0;
            r_word_idx <= '0;
            r_last_idx <= '0;
        end else if (w_xfer) begin
            if (r_state == S_HDR) begin
                r_csum     <= byte_data;
                r_word_idx <= '0;
                r_last_idx <= ADDR_W'(byte_data - 8'd1);
            end else if (r_state == S_DATA) begin
                r_csum <= r_csum ^ byte_data;
                if (w_word_done) begin
                    r_word_idx <= r_word_idx + 1'b1;
                end
            end
        end
    end

    imem_word_assembler #(
        .ADDR_W (ADDR_W)
    ) u_assembler (
        .clk       (clk),
        .rst       (rst),
        .lane_en   (w_lane_en),
        .byte_data (byte_data),
        .word_addr (r_word_idx),
        .word_done (w_word_done),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    // Status follows the state register directly, so an asynchronous reset
    // restores it immediately and done/error are mutually exclusive by design.
    assign done     = (r_state == S_DONE);
    assign error    = (r_state == S_ERR);
    assign cpu_hold = (r_state != S_DONE);

endmodule : imem_program_loader
`default_nettype wire

// File: tb/tb_imem_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_program_loader
//  Purpose  : Self-checking bench for imem_program_loader. Expected memory
//             writes are pushed to a scoreboard as the 4th byte of each word
//             is driven and popped when the DUT strobes wr_en.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_program_loader;

    logic        clk;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    imem_program_loader #(
        .DEPTH  (64),
        .ADDR_W (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t        sb[$];
    wr_t        mon_e;
    logic [7:0] img[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_wr     = 0;
    int         cyc      = 0;
    int         last_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write,
    // including the cycle it was due in.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            n_wr++;
            if (sb.size() == 0) begin
                check("unexpected_write", 64'(wr_addr), 64'hFFFF);
            end else begin
                mon_e = sb.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
                check("wr_data", 64'(wr_data), 64'(mon_e.data));
                check("wr_latency_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        sb.delete();
        n_wr = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_byte_ready"}, 64'(byte_ready), 64'd1);
        check({tag, "_wr_en"},      64'(wr_en),      64'd0);
        check({tag, "_wr_addr"},    64'(wr_addr),    64'd0);
        check({tag, "_wr_data"},    64'(wr_data),    64'd0);
        check({tag, "_cpu_hold"},   64'(cpu_hold),   64'd1);
        check({tag, "_done"},       64'(done),       64'd0);
        check({tag, "_error"},      64'(error),      64'd0);
    endtask

    // Drives one byte (optionally after random idle cycles) and records the
    // cycle number of the edge that accepts it.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                byte_valid = 1'b0;
                byte_data  = 8'hXX;
            end
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        last_cyc = cyc;
    endtask

    // Sends the whole image in img; the expected write for each word is
    // formed from its four bytes and queued once its last byte is accepted.
    task automatic load_image(input bit gaps);
        int          nwords;
        logic [31:0] w;
        nwords = (img.size() > 0 && img[0] <= 8'd64) ? int'(img[0]) : 0;
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], gaps);
            if (i >= 1 && i <= 4 * nwords && ((i - 1) % 4) == 3) begin
                w = {img[i], img[i-1], img[i-2], img[i-3]};
                sb.push_back('{addr: 6'((i - 1) / 4), data: w, cyc: last_cyc});
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic finish_scenario(input string tag, input int exp_wr,
                                   input bit exp_done, input bit exp_err);
        repeat (4) @(negedge clk);
        check({tag, "_pending_writes"}, 64'(sb.size()), 64'd0);
        check({tag, "_write_count"},    64'(n_wr),      64'(exp_wr));
        check({tag, "_done"},           64'(done),      64'(exp_done));
        check({tag, "_error"},          64'(error),     64'(exp_err));
        check({tag, "_cpu_hold"},       64'(cpu_hold),  64'(!exp_done));
        check({tag, "_byte_ready"},     64'(byte_ready), 64'd0);
        check({tag, "_done_and_error"}, 64'(done & error), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        // Two-word load, valid held high.
        apply_reset();
        check_reset_values("reset");
        img = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
        load_image(1'b0);
        check("good_done_after_csum", 64'(done), 64'd1);
        finish_scenario("good", 2, 1'b1, 1'b0);

        // Same stream, wrong checksum.
        apply_reset();
        img = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h74};
        load_image(1'b0);
        finish_scenario("badcsum", 2, 1'b0, 1'b1);

        // Oversized header: error at once, later bytes ignored.
        apply_reset();
        img = '{8'h41};
        load_image(1'b0);
        check("hdr65_error_next_cycle", 64'(error), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = 8'h11 * 8'(i);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        finish_scenario("hdr65", 0, 1'b0, 1'b1);

        // Header exactly DEPTH is legal: accepted into payload phase.
        apply_reset();
        img = '{8'h40};
        load_image(1'b0);
        check("hdr64_not_error", 64'(error), 64'd0);
        check("hdr64_ready", 64'(byte_ready), 64'd1);

        // Empty image.
        apply_reset();
        img = '{8'h00, 8'h00};
        load_image(1'b0);
        finish_scenario("empty", 0, 1'b1, 1'b0);

        // Two-word load with random gaps.
        apply_reset();
        img = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
        load_image(1'b1);
        finish_scenario("gaps", 2, 1'b1, 1'b0);

        // Asynchronous reset mid-word, then a full reload.
        apply_reset();
        img = '{8'h02, 8'h93, 8'h00};
        load_image(1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b0;
        check("midrst_no_write", 64'(n_wr), 64'd0);
        n_wr = 0;
        img = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
        load_image(1'b0);
        finish_scenario("reload", 2, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_imem_program_loader
`default_nettype wire
